mips_muldiv_unit: RTL and testbench
===================================

MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width in bits; legal range 4..64.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 clk_enable  input  1  when low, all state including outputs SHALL hold.
REQ-005 start  input  1  issue request; sampled only when busy=0.
REQ-006 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 rs_data  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-008 rt_data  input  WIDTH  rt operand: multiplier or divisor.
REQ-009 busy  output  1  high while a multiply/divide iterates.
REQ-010 done  output  1  one-cycle completion pulse for MULT/MULTU/DIV/DIVU.
REQ-011 div_by_zero  output  1  high only together with done of a divide with rt_data=0.
REQ-012 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, FIX; state and iteration counter change only on edges where clk_enable=1.
REQ-014 Accept = start & ~busy & clk_enable in IDLE; operands SHALL be latched at the accept edge, and later changes to rs_data/rt_data SHALL have no effect.
REQ-015 start while busy=1 SHALL be ignored, with no effect on the running operation.
REQ-016 Reserved op codes SHALL be ignored: no state change, no done.
REQ-017 MTHI/MTLO SHALL write hi/lo from rs_data at the accept edge, leave the other register unchanged, never assert busy, and produce no done.
REQ-018 MULT/MULTU/DIV/DIVU: IDLE->MUL or DIV at the accept edge, and busy=1 from then on.
REQ-019 One radix-2 iteration per enabled edge; after WIDTH iterations the unit SHALL enter FIX.
REQ-020 FIX edge: write hi/lo, assert done for exactly one cycle, clear busy, return to IDLE.
REQ-021 Latency: busy high for exactly WIDTH+1 enabled cycles; done high in the cycle after busy falls; a new start is accepted in that same cycle.
REQ-022 Multiply: {hi,lo} SHALL equal the full 2*WIDTH-bit product; MULT is two's-complement signed, MULTU is unsigned.
REQ-023 Divide results: lo = quotient truncated toward zero; hi = remainder.
REQ-024 Signed divide sign rules: remainder sign equals dividend sign; quotient is negative when operand signs differ.
REQ-025 Signed operands SHALL be converted to magnitudes at accept and the result signs applied in FIX, with arithmetic modulo 2^WIDTH.
REQ-026 DIV of most-negative by -1 SHALL give lo=most-negative and hi=0, with no flag.
REQ-027 Divide by zero: detected at accept, state goes directly to FIX, done=div_by_zero=1 on the next edge, and hi/lo SHALL remain unchanged.
REQ-028 hi/lo SHALL change only at the FIX edge or an MTHI/MTLO accept, never during iteration.

Reset
REQ-029 Reset SHALL take priority over clk_enable and start.
REQ-030 Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
REQ-031 Reset mid-operation SHALL abort the operation with no done pulse, and a start in the first cycle after reset deasserts SHALL be accepted.

Verification (WIDTH=32)
REQ-032 MULTU rs=FFFFFFFF rt=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high for 33 cycles, then done pulses once.
REQ-033 MULT rs=FFFFFFFD(-3) rt=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB.
REQ-034 DIV rs=FFFFFFF9(-7) rt=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 100/7 -> lo=0000000E, hi=00000002.
REQ-035 DIV rs=80000000 rt=FFFFFFFF -> lo=80000000, hi=00000000, div_by_zero=0.
REQ-036 MTHI 12345678, then DIVU rs=5 rt=0 -> done=div_by_zero=1 one cycle after accept; hi=12345678, lo=0 unchanged.
REQ-037 Start MULT, second start at cycle 5, reset at cycle 10 -> second start ignored; after reset busy=0, hi=lo=0, no done; immediate new MULTU completes correctly; clk_enable low for 3 cycles mid-op extends latency by exactly 3 cycles.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS HI/LO unit: radix-2 shift-add multiply and restoring divide.
// Signed operands are converted to magnitudes at issue; result signs are applied in FIX.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_r_q, neg_r_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg, rt_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod;

  // Everything holds while clk_enable is low; reset overrides the enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (clk_enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      neg_r_q  <= neg_r_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    rt_zero = (rt_data == '0);
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001: state_d = S_MUL;
            3'b010, 3'b011: state_d = rt_zero ? S_FIX : S_DIV;
            default:        state_d = S_IDLE;
          endcase
        end
      end
      S_MUL:   if (cnt_q == CW'(1)) state_d = S_FIX;
      S_DIV:   if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_neg    = ~op[0] & rs_data[WIDTH-1];
    b_neg    = ~op[0] & rt_data[WIDTH-1];
    a_mag    = a_neg ? -rs_data : rs_data;
    b_mag    = b_neg ? -rt_data : rt_data;
    mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {acc_q, mq_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    prod     = {acc_q, mq_q};
    if (neg_q) prod = -prod;

    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    neg_r_d  = neg_r_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !op[2]) begin
          acc_d    = '0;
          mq_d     = a_mag;
          opb_d    = b_mag;
          is_div_d = op[1];
          neg_d    = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          dz_d     = op[1] & rt_zero;
          cnt_d    = (op[1] & rt_zero) ? '0 : CW'(WIDTH);
        end else if (start && op == 3'b100) begin
          hi_d = rs_data;
        end else if (start && op == 3'b101) begin
          lo_d = rs_data;
        end
      end
      S_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
      end
      S_DIV: begin
        // rem_diff[WIDTH] set means the trial subtraction went negative: restore.
        acc_d = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], ~rem_diff[WIDTH]};
        cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        done_d = 1'b1;
        cnt_d  = '0;
        if (dz_q) begin
          dbz_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_q   ? -mq_q  : mq_q;
          hi_d = neg_r_q ? -acc_q : acc_q;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    div_by_zero = dbz_q;
    hi          = hi_q;
    lo          = lo_q;
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit at WIDTH=32: inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Called just after a falling edge; returns at the falling edge where busy is low.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bc);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0; rs_data = 32'h5A5A5A5A; rt_data = 32'h0;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
  endtask

  task automatic test_multu_max();
    int bc;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
    total++; if (bc !== 33) begin bad++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL multu_done got=%b exp=1", done); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL multu_dbz got=%b exp=0", div_by_zero); end
    total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
    total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mult_signed();
    int bc;
    run_op(3'b000, 32'hFFFFFFFD, 32'h00000007, bc);
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin bad++;
      $display("FAIL mult_neg3x7 got=%h_%h exp=ffffffff_ffffffeb", hi, lo); end
    run_op(3'b000, 32'h00000005, 32'hFFFFFFFC, bc);
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEC) begin bad++;
      $display("FAIL mult_5xneg4 got=%h_%h exp=ffffffff_ffffffec", hi, lo); end
    run_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, bc);
    total++; if (hi !== 32'h0 || lo !== 32'h1) begin bad++;
      $display("FAIL mult_neg1xneg1 got=%h_%h exp=00000000_00000001", hi, lo); end
    run_op(3'b000, 32'h00000000, 32'hFFFFFFFB, bc);
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++;
      $display("FAIL mult_0xneg5 got=%h_%h exp=00000000_00000000", hi, lo); end
  endtask

  task automatic test_divide();
    int bc;
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, bc);
    total++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin bad++;
      $display("FAIL div_neg7_2 got=lo %h hi %h exp=lo fffffffd hi ffffffff", lo, hi); end
    total++; if (bc !== 33) begin bad++; $display("FAIL div_busy_cycles got=%0d exp=33", bc); end
    run_op(3'b011, 32'd100, 32'd7, bc);
    total++; if (lo !== 32'h0000000E || hi !== 32'h00000002) begin bad++;
      $display("FAIL divu_100_7 got=lo %h hi %h exp=lo 0000000e hi 00000002", lo, hi); end
    run_op(3'b010, 32'h00000007, 32'hFFFFFFFE, bc);
    total++; if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin bad++;
      $display("FAIL div_7_neg2 got=lo %h hi %h exp=lo fffffffd hi 00000001", lo, hi); end
    run_op(3'b011, 32'hFFFFFFFF, 32'h00000010, bc);
    total++; if (lo !== 32'h0FFFFFFF || hi !== 32'h0000000F) begin bad++;
      $display("FAIL divu_big got=lo %h hi %h exp=lo 0fffffff hi 0000000f", lo, hi); end
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, bc);
    total++; if (lo !== 32'h80000000 || hi !== 32'h00000000) begin bad++;
      $display("FAIL div_minneg got=lo %h hi %h exp=lo 80000000 hi 00000000", lo, hi); end
    total++; if (done !== 1'b1 || div_by_zero !== 1'b0) begin bad++;
      $display("FAIL div_minneg_flags got=done %b dbz %b exp=done 1 dbz 0", done, div_by_zero); end
  endtask

  task automatic test_mthi_div_zero();
    int bc;
    do_reset();
    start = 1'b1; op = 3'b100; rs_data = 32'h12345678; rt_data = 32'h0;
    @(negedge clk);
    start = 1'b0;
    total++; if (hi !== 32'h12345678 || lo !== 32'h0) begin bad++;
      $display("FAIL mthi got=hi %h lo %h exp=hi 12345678 lo 00000000", hi, lo); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL mthi_flags got=busy %b done %b exp=0 0", busy, done); end
    start = 1'b1; op = 3'b101; rs_data = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    total++; if (lo !== 32'hCAFEF00D || hi !== 32'h12345678) begin bad++;
      $display("FAIL mtlo got=hi %h lo %h exp=hi 12345678 lo cafef00d", hi, lo); end
    start = 1'b1; op = 3'b101; rs_data = 32'h0;
    @(negedge clk);
    start = 1'b0;
    run_op(3'b011, 32'd5, 32'd0, bc);
    total++; if (bc !== 1) begin bad++; $display("FAIL dz_busy_cycles got=%0d exp=1", bc); end
    total++; if (done !== 1'b1 || div_by_zero !== 1'b1) begin bad++;
      $display("FAIL dz_flags got=done %b dbz %b exp=1 1", done, div_by_zero); end
    total++; if (hi !== 32'h12345678 || lo !== 32'h0) begin bad++;
      $display("FAIL dz_hilo got=hi %h lo %h exp=hi 12345678 lo 00000000", hi, lo); end
    @(negedge clk);
    total++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin bad++;
      $display("FAIL dz_pulse got=done %b dbz %b exp=0 0", done, div_by_zero); end
  endtask

  task automatic test_reserved();
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    start = 1'b1; op = 3'b110; rs_data = 32'h11111111; rt_data = 32'h3;
    @(negedge clk);
    op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL reserved_flags got=busy %b done %b exp=0 0", busy, done); end
    total++; if (hi !== h0 || lo !== l0) begin bad++;
      $display("FAIL reserved_hilo got=hi %h lo %h exp=hi %h lo %h", hi, lo, h0, l0); end
  endtask

  task automatic test_start_while_busy();
    int bc;
    start = 1'b1; op = 3'b000; rs_data = 32'h00000005; rt_data = 32'hFFFFFFFC;
    @(posedge clk); #1;
    start = 1'b0; rs_data = 32'h0; rt_data = 32'h0;
    bc = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (busy) bc++; end
    start = 1'b1; op = 3'b100; rs_data = 32'h11111111;
    @(negedge clk);
    if (busy) bc++;
    start = 1'b1; op = 3'b001; rs_data = 32'h2;
    @(negedge clk);
    if (busy) bc++;
    start = 1'b0;
    total++; if (hi === 32'h11111111) begin bad++; $display("FAIL busy_mthi_ignored got=%h exp=not 11111111", hi); end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
    total++; if (bc !== 33) begin bad++; $display("FAIL busy_start_cycles got=%0d exp=33", bc); end
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEC) begin bad++;
      $display("FAIL busy_start_result got=%h_%h exp=ffffffff_ffffffec", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int bc;
    run_op(3'b001, 32'd3, 32'd4, bc);
    total++; if (done !== 1'b1 || lo !== 32'd12) begin bad++;
      $display("FAIL b2b_first got=done %b lo %h exp=done 1 lo 0000000c", done, lo); end
    run_op(3'b011, 32'd100, 32'd7, bc);
    total++; if (bc !== 33) begin bad++; $display("FAIL b2b_cycles got=%0d exp=33", bc); end
    total++; if (lo !== 32'hE || hi !== 32'h2) begin bad++;
      $display("FAIL b2b_second got=lo %h hi %h exp=lo 0000000e hi 00000002", lo, hi); end
  endtask

  task automatic test_clk_enable();
    int bc;
    start = 1'b1; op = 3'b001; rs_data = 32'h00010001; rt_data = 32'h00010001;
    @(posedge clk); #1;
    start = 1'b0;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
      if (bc == 5) clk_enable = 1'b0;
      if (bc == 8) clk_enable = 1'b1;
    end
    clk_enable = 1'b1;
    total++; if (bc !== 36) begin bad++; $display("FAIL enable_cycles got=%0d exp=36", bc); end
    total++; if (hi !== 32'h00000001 || lo !== 32'h00020001) begin bad++;
      $display("FAIL enable_result got=%h_%h exp=00000001_00020001", hi, lo); end
  endtask

  task automatic test_reset_midop();
    int bc;
    do_reset();
    start = 1'b1; op = 3'b000; rs_data = 32'h00000123; rt_data = 32'h00000456;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) begin start = 1'b1; op = 3'b101; rs_data = 32'hDEADBEEF; end
      if (c == 6) begin
        start = 1'b0;
        total++; if (lo !== 32'h0 || busy !== 1'b1) begin bad++;
          $display("FAIL midop_start_ignored got=lo %h busy %b exp=lo 00000000 busy 1", lo, busy); end
      end
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin bad++;
      $display("FAIL midop_reset got=busy %b done %b hi %h lo %h exp=0 0 0 0", busy, done, hi, lo); end
    reset = 1'b0;
    run_op(3'b001, 32'h0000FFFF, 32'h00010000, bc);
    total++; if (bc !== 33) begin bad++; $display("FAIL postreset_cycles got=%0d exp=33", bc); end
    total++; if (hi !== 32'h0 || lo !== 32'hFFFF0000 || done !== 1'b1) begin bad++;
      $display("FAIL postreset_result got=%h_%h done %b exp=00000000_ffff0000 done 1", hi, lo, done); end
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'b000;
    rs_data = 32'h0; rt_data = 32'h0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_divide();
    test_mthi_div_zero();
    test_reserved();
    test_start_while_busy();
    test_back_to_back();
    test_clk_enable();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
